// File: rtl/tf_stage_sequencer.sv
// tf_stage_sequencer
// Walks the per-row twiddle-factor ROMs through every stage of the radix-16 FFT:
// drives the active-low ROM enable, stage_counter, the 16-cycle cnt and tf_idx, and
// delays each ROM issue by ROM_LAT cycles to flag valid factors to the multipliers.
// Optional feature macro: TF_TRIVIAL_EN adds tf_trivial (issued tf_idx == 0, i.e. the
// unity factor), aligned with tf_valid, so the multiplier can bypass.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start, ROM disabled
// S_RUN   | issuing ROM reads; stall holds the counters with cen=1
// S_DRAIN | ROM_LAT cycles with cen=1 so in-flight reads complete
// S_DONE  | one-cycle done pulse, start ignored
//
// Reset is asynchronous and asserted while rst_n is high.
// The issue decision is registered: stall sampled at an edge sets cen for the next
// cycle, and counters advance only on edges that close a cen=0 cycle, so cnt/tf_idx
// always show the address presented while cen=0.

module tf_stage_sequencer #(
  parameter int SC_WIDTH    = 3,
  parameter int NUM_STAGES  = 4,
  parameter int GROUPS      = 64,
  parameter int IDX_WIDTH   = 6,
  parameter int TF_IDX_INIT = 1,
  parameter int ROM_LAT     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  output logic                 cen,
  output logic [SC_WIDTH-1:0]  stage_counter,
  output logic [3:0]           cnt,
  output logic [IDX_WIDTH-1:0] tf_idx,
  output logic                 tf_valid,
  output logic                 busy,
`ifdef TF_TRIVIAL_EN
  output logic                 done,
  output logic                 tf_trivial
`else
  output logic                 done
`endif
);

  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0]        GRP_LAST   = GW'(GROUPS - 1);
  localparam logic [SC_WIDTH-1:0]  STAGE_LAST = SC_WIDTH'(NUM_STAGES - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_INIT   = IDX_WIDTH'(TF_IDX_INIT);
  localparam logic [1:0]           DRAIN_LAST = 2'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [GW-1:0]      group;
  logic [1:0]         drain_cnt;
  logic [ROM_LAT-1:0] valid_pipe;

  // Sequencer FSM: issue control, stage/group/index counters and status outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= S_IDLE;
      cen           <= 1'b1;
      stage_counter <= '0;
      cnt           <= '0;
      group         <= '0;
      tf_idx        <= IDX_INIT;
      drain_cnt     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cen  <= 1'b1;
          done <= 1'b0;
          if (start) begin
            state         <= S_RUN;
            busy          <= 1'b1;
            cen           <= stall;
            cnt           <= '0;
            group         <= '0;
            stage_counter <= '0;
            tf_idx        <= IDX_INIT;
          end
        end
        S_RUN: begin
          cen <= stall;
          if (!cen) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              group  <= group + 1'b1;
              tf_idx <= tf_idx + 1'b1;
              if (group == GRP_LAST) begin
                group <= '0;
                if (stage_counter == STAGE_LAST) begin
                  state     <= S_DRAIN;
                  cen       <= 1'b1;
                  drain_cnt <= DRAIN_LAST;
                end else begin
                  stage_counter <= stage_counter + 1'b1;
                  tf_idx        <= IDX_INIT;
                end
              end
            end
          end
        end
        S_DRAIN: begin
          cen <= 1'b1;
          if (drain_cnt == 2'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        S_DONE: begin
          cen   <= 1'b1;
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ROM read latency tracking: tf_valid is cen=0 delayed ROM_LAT cycles, never gated
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_pipe <= '0;
    end else begin
      for (int i = ROM_LAT - 1; i > 0; i--) valid_pipe[i] <= valid_pipe[i-1];
      valid_pipe[0] <= ~cen;
    end
  end

  assign tf_valid = valid_pipe[ROM_LAT-1];

`ifdef TF_TRIVIAL_EN
  logic [ROM_LAT-1:0] triv_pipe;

  // Unity-factor flag follows the same latency as tf_valid
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      triv_pipe <= '0;
    end else begin
      for (int i = ROM_LAT - 1; i > 0; i--) triv_pipe[i] <= triv_pipe[i-1];
      triv_pipe[0] <= ~cen & (tf_idx == '0);
    end
  end

  assign tf_trivial = triv_pipe[ROM_LAT-1];
`endif

endmodule

// File: tb/tb_tf_stage_sequencer.sv
// tb_tf_stage_sequencer
// Self-checking bench for tf_stage_sequencer with default parameters. A reference
// model tracks the number of issued ROM reads k and derives stage/cnt/tf_idx from it
// arithmetically; scenario and spot-check tables cover the documented timing cases,
// followed by randomized start/stall traffic and mid-transform resets.

module tb_tf_stage_sequencer;

  localparam int SC_WIDTH    = 3;
  localparam int NUM_STAGES  = 4;
  localparam int GROUPS      = 64;
  localparam int IDX_WIDTH   = 6;
  localparam int TF_IDX_INIT = 1;
  localparam int ROM_LAT     = 1;
  localparam int TOTAL       = NUM_STAGES * GROUPS * 16;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 stall;
  logic                 cen;
  logic [SC_WIDTH-1:0]  stage_counter;
  logic [3:0]           cnt;
  logic [IDX_WIDTH-1:0] tf_idx;
  logic                 tf_valid;
  logic                 busy;
  logic                 done;
`ifdef TF_TRIVIAL_EN
  logic                 tf_trivial;
`endif

  tf_stage_sequencer #(
    .SC_WIDTH(SC_WIDTH), .NUM_STAGES(NUM_STAGES), .GROUPS(GROUPS),
    .IDX_WIDTH(IDX_WIDTH), .TF_IDX_INIT(TF_IDX_INIT), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .cen(cen),
    .stage_counter(stage_counter), .cnt(cnt), .tf_idx(tf_idx),
    .tf_valid(tf_valid), .busy(busy),
`ifdef TF_TRIVIAL_EN
    .done(done), .tf_trivial(tf_trivial)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int mode;
  int k;
  bit cen_e;
  int dleft;
  bit vh [4];
  bit th [4];
  int triv_cnt;

  function automatic int idx_of(input int kk);
    return (TF_IDX_INIT + (kk / 16) % GROUPS) % (1 << IDX_WIDTH);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; k = 0; cen_e = 1'b1; dleft = 0;
    for (int i = 0; i < 4; i++) begin vh[i] = 1'b0; th[i] = 1'b0; end
  endtask

  task automatic model_step(input bit s_start, input bit s_stall);
    bit old_cen, old_triv;
    old_cen  = cen_e;
    old_triv = (mode == M_RUN) && !cen_e && (idx_of(k) == 0);
    for (int i = 3; i > 0; i--) begin vh[i] = vh[i-1]; th[i] = th[i-1]; end
    vh[0] = !old_cen;
    th[0] = old_triv;
    case (mode)
      M_IDLE: if (s_start) begin mode = M_RUN; k = 0; cen_e = s_stall; end
      M_RUN: begin
        if (!old_cen) k++;
        if (k == TOTAL) begin mode = M_DRAIN; dleft = ROM_LAT; cen_e = 1'b1; end
        else cen_e = s_stall;
      end
      M_DRAIN: begin dleft--; if (dleft == 0) mode = M_DONE; end
      default: mode = M_IDLE;
    endcase
  endtask

  // one clock: model sees the inputs in force before the edge, outputs checked 1ns after
  task automatic tick();
    bit s_start, s_stall;
    s_start = start;
    s_stall = stall;
    @(posedge clk);
    model_step(s_start, s_stall);
    #1;
    check("cen", cen, cen_e);
    check("busy", busy, (mode == M_RUN || mode == M_DRAIN));
    check("done", done, (mode == M_DONE));
    check("tf_valid", tf_valid, vh[ROM_LAT-1]);
`ifdef TF_TRIVIAL_EN
    check("tf_trivial", tf_trivial, th[ROM_LAT-1]);
    if (tf_trivial) triv_cnt++;
`endif
    if (mode == M_RUN) begin
      check("stage_counter", stage_counter, k / (GROUPS * 16));
      check("cnt", cnt, k % 16);
      check("tf_idx", tf_idx, idx_of(k));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_cen", cen, 1);
    check("rst_stage", stage_counter, 0);
    check("rst_cnt", cnt, 0);
    check("rst_tf_idx", tf_idx, TF_IDX_INIT);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tf_valid", tf_valid, 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int stall_k;
    int stall_len;
    bit hold_start;
    int exp_done;
  } scen_t;

  typedef struct {
    int cyc;
    int exp_idx;
    int exp_stage;
  } spot_t;

  scen_t scen [5];
  spot_t spot [9];

  initial begin
    scen[0] = '{-1,            0, 1'b0, 4098};
    scen[1] = '{2 * 1024 + 7,  5, 1'b0, 4103};
    scen[2] = '{-1,            0, 1'b1, 4098};
    scen[3] = '{100,           3, 1'b0, 4101};
    scen[4] = '{TOTAL - 2,     2, 1'b0, 4100};

    spot[0] = '{1,    1,  0};
    spot[1] = '{16,   1,  0};
    spot[2] = '{17,   2,  0};
    spot[3] = '{32,   2,  0};
    spot[4] = '{1008, 63, 0};
    spot[5] = '{1009, 0,  0};
    spot[6] = '{1025, 1,  1};
    spot[7] = '{2049, 1,  2};
    spot[8] = '{4096, 0,  3};

    start = 1'b0;
    stall = 1'b0;
    rst_n = 1'b0;
    triv_cnt = 0;
    model_reset();
    apply_reset();
    tick();

    for (int s = 0; s < 5; s++) begin
      int c, done_at, n_done, stall_left;
      c = 0; done_at = -1; n_done = 0; stall_left = 0;
      triv_cnt = 0;
      start = 1'b1;
      while (done_at < 0 && c < 6000) begin
        tick();
        c++;
        if (!scen[s].hold_start) start = 1'b0;
        if (done) begin done_at = c; n_done++; end
        if (s == 0)
          for (int j = 0; j < 9; j++)
            if (spot[j].cyc == c) begin
              check("spot_tf_idx", tf_idx, spot[j].exp_idx);
              check("spot_stage", stage_counter, spot[j].exp_stage);
              check("spot_cen", cen, 0);
            end
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) stall = 1'b0;
        end else if (mode == M_RUN && !cen_e && k == scen[s].stall_k) begin
          stall = 1'b1;
          stall_left = scen[s].stall_len;
        end
      end
      check("done_cycle", done_at, scen[s].exp_done);
`ifdef TF_TRIVIAL_EN
      check("trivial_count", triv_cnt, 16 * NUM_STAGES);
`endif
      tick();
      if (done) n_done++;
      tick();
      if (done) n_done++;
      check("done_pulses", n_done, 1);
      check("restart_busy", busy, scen[s].hold_start ? 1 : 0);
      if (scen[s].hold_start) begin
        start = 1'b0;
        for (int j = 0; j < 20; j++) tick();
        apply_reset();
        tick();
        check("post_rst_done", done, 0);
      end
      for (int j = 0; j < 3; j++) tick();
    end

    for (int r = 0; r < 3; r++) begin
      int len;
      len = 3000 + int'($urandom_range(0, 2000));
      for (int j = 0; j < len; j++) begin
        start = ($urandom_range(0, 3) == 0);
        stall = ($urandom_range(0, 7) == 0);
        tick();
      end
      start = 1'b0;
      stall = 1'b0;
      apply_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
